// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, TX queue FSM encoding and the
// baud divider helper used by the transmitter, receiver and TX queue.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    TXQ_IDLE      = 2'd0,
    TXQ_ISSUE     = 2'd1,
    TXQ_WAIT_DONE = 2'd2
  } txq_state_t;

  // clk cycles per UART bit
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO for the UART TX queue.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_en, wr_data    push strobe and byte; dropped (overflow pulse) when full
//   rd_en, rd_data_c  pop strobe and combinational head byte
//   full, empty       registered level decodes
//   level             entries stored, 0..DEPTH
//   overflow          one-cycle pulse after a dropped write
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [UART_DATA_W-1:0]   wr_data,
  input  logic                     rd_en,
  output logic [UART_DATA_W-1:0]   rd_data_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   overflow_q, overflow_d;
  logic                   push, pop;

  // Full is judged on the registered level; a same-cycle pop does not free a slot.
  assign push = wr_en & ~full_q;
  assign pop  = rd_en & ~empty_q;

  // Next-state for pointers, level and flags
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    full_d     = (level_d == LVL_W'(DEPTH));
    empty_d    = (level_d == '0);
    overflow_d = wr_en & full_q;
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and issue sequencer in front of the UART transmitter.
// Buffers host bytes, presents one at a time on dintx/newd, holds newd for
// HOLD_CYCLES so the divided baud clock can sample it, then waits for donetx.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wr_en, wr_data             host write
//   full, empty, level         queue status
//   overflow                   one-cycle pulse on a dropped write
//   newd, dintx                request and byte to the transmitter
//   donetx                     transmitter done (asynchronous)
//   busy                       high while issuing or waiting for done
//   tx_timeout                 WAIT_DONE timeout pulse
// Optional feature macro: UART_TXQ_TIMEOUT_EN (WAIT_DONE timeout; otherwise
// tx_timeout is tied 0 and WAIT_DONE waits indefinitely).
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned CLK_FREQ       = 1000000,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter int unsigned HOLD_CYCLES    = 2 * (baud_div(CLK_FREQ, BAUD_RATE) / 2 + 1) + 2,
  parameter int unsigned TIMEOUT_CYCLES = 16 * baud_div(CLK_FREQ, BAUD_RATE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [UART_DATA_W-1:0]   wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     newd,
  output logic [UART_DATA_W-1:0]   dintx,
  input  logic                     donetx,
  output logic                     busy,
  output logic                     tx_timeout
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] ST_IDLE      = TXQ_IDLE;
  localparam logic [1:0] ST_ISSUE     = TXQ_ISSUE;
  localparam logic [1:0] ST_WAIT_DONE = TXQ_WAIT_DONE;

  logic [1:0]             state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   newd_q, newd_d;
  logic [UART_DATA_W-1:0] dintx_q, dintx_d;
  logic                   busy_q, busy_d;
  logic                   pend_q, pend_d;
  logic [2:0]             sync_q, sync_d;
  logic                   done_rise;
  logic                   pop_c;
  logic [UART_DATA_W-1:0] head_c;
  logic                   fifo_empty;

`ifdef UART_TXQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tx_timeout_q, tx_timeout_d;
`endif

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (pop_c),
    .rd_data_c (head_c),
    .full      (full),
    .empty     (fifo_empty),
    .level     (level),
    .overflow  (overflow)
  );

  // Two-flop synchroniser plus an edge-detect flop for donetx
  assign sync_d    = {sync_q[1:0], donetx};
  assign done_rise = sync_q[1] & ~sync_q[2];

  // Issue sequencer next-state and outputs
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    newd_d  = newd_q;
    dintx_d = dintx_q;
    pend_d  = pend_q;
    pop_c   = 1'b0;
`ifdef UART_TXQ_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tx_timeout_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          dintx_d = head_c;
          newd_d  = 1'b1;
          hold_d  = HOLD_W'(HOLD_CYCLES - 1);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A fast transmitter can finish before newd drops; remember it.
        if (done_rise) begin
          pend_d = 1'b1;
        end
        if (hold_q == '0) begin
          newd_d  = 1'b0;
          state_d = ST_WAIT_DONE;
`ifdef UART_TXQ_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (done_rise || pend_q) begin
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end
`ifdef UART_TXQ_TIMEOUT_EN
        // Pulse lands in the cycle the counter reaches the limit; leave then.
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES)) begin
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d    = tmo_cnt_q + TMO_W'(1);
          tx_timeout_d = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        newd_d  = 1'b0;
        pend_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      newd_q  <= 1'b0;
      dintx_q <= '0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      newd_q  <= newd_d;
      dintx_q <= dintx_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      sync_q  <= sync_d;
    end
  end

`ifdef UART_TXQ_TIMEOUT_EN
  // WAIT_DONE timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q    <= '0;
      tx_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end
  assign tx_timeout = tx_timeout_q;
`else
  assign tx_timeout = 1'b0;
`endif

  assign empty = fifo_empty;
  assign newd  = newd_q;
  assign dintx = dintx_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue with a behavioural transmitter model
// that raises donetx a fixed delay after newd falls.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int          HOLD   = 108;
  localparam int          TMO    = 1664;
  localparam int          TX_DLY = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, newd, busy, tx_timeout;
  logic [4:0] level;
  logic [7:0] dintx;
  logic       donetx = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         len_q[$];
  int         lat_q[$];
  int         gap_q[$];

  uart_tx_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .newd       (newd),
    .dintx      (dintx),
    .donetx     (donetx),
    .busy       (busy),
    .tx_timeout (tx_timeout)
  );

  always #5 clk = ~clk;

  // Transmitter model
  int   tx_wait = -1;
  int   done_hold = 0;
  int   kick_req = 0;
  int   kick_seen = 0;
  bit   tx_stall = 1'b0;
  logic tx_newd_p = 1'b0;
  time  done_t = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      tx_wait = -1; done_hold = 0; donetx = 1'b0; tx_newd_p = 1'b0; kick_seen = kick_req;
    end else begin
      if (kick_req != kick_seen) begin kick_seen = kick_req; tx_wait = 0; end
      if (tx_newd_p && !newd && !tx_stall) tx_wait = TX_DLY;
      if (done_hold > 0) begin
        done_hold--;
        if (done_hold == 0) donetx = 1'b0;
      end
      if (tx_wait > 0) tx_wait--;
      else if (tx_wait == 0) begin
        donetx = 1'b1; done_t = $time; done_hold = 4; tx_wait = -1;
      end
      tx_newd_p = newd;
    end
  end

  // Output monitor: captures issued bytes, hold lengths and latencies
  bit         in_pulse = 1'b0;
  logic [7:0] cur_b = 8'h00;
  int         hold_len = 0;
  logic       busy_p = 1'b0;
  int         tmo_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pulse = 1'b0; busy_p = 1'b0;
    end else begin
      if (newd && !in_pulse) begin
        in_pulse = 1'b1; cur_b = dintx; hold_len = 0;
        gap_q.push_back(int'($time - done_t));
      end
      if (newd) hold_len++;
      else if (in_pulse) begin
        in_pulse = 1'b0; obs_q.push_back(cur_b); len_q.push_back(hold_len);
      end
      if (busy_p && !busy) lat_q.push_back(int'($time - done_t));
      busy_p = busy;
      if (tx_timeout) tmo_seen++;
    end
  end

  task automatic write_byte(input logic [7:0] b, input bit accept);
    wr_en = 1'b1; wr_data = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_obs(input int n, input string name);
    int b = 0;
    while (obs_q.size() < n && b < 20000) begin @(negedge clk); b++; end
    total_cnt++;
    if (obs_q.size() < n) $display("FAIL %s_wait: got %0d bytes, need %0d", name, obs_q.size(), n);
    else pass_cnt++;
  endtask

  task automatic wait_idle(input string name);
    int b = 0;
    while ((busy || !empty || tx_wait >= 0 || done_hold > 0) && b < 20000) begin @(negedge clk); b++; end
    repeat (4) @(negedge clk);
    if (b >= 20000) begin
      total_cnt++;
      $display("FAIL %s_idle: queue did not drain within budget", name);
    end
  endtask

  task automatic check_stream(input string name);
    logic [7:0] o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      total_cnt++;
      if (exp_q.size() == 0) $display("FAIL %s_extra: got %h, none expected", name, o);
      else begin
        e = exp_q.pop_front();
        if (o !== e) $display("FAIL %s_byte: got %h want %h", name, o, e);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s_missing: %0d bytes not seen", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({empty, full, overflow, newd, busy, tx_timeout} !== 6'b100000)
      $display("FAIL reset_flags: got e%b f%b o%b n%b b%b t%b want e1 f0 o0 n0 b0 t0",
               empty, full, overflow, newd, busy, tx_timeout);
    else pass_cnt++;
    total_cnt++;
    if (level !== 5'd0 || dintx !== 8'h00) $display("FAIL reset_data: got level %0d dintx %h want 0 00", level, dintx);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    lat_q.delete(); len_q.delete(); obs_q.delete();
    write_byte(8'hA5, 1'b1);
    total_cnt++;
    if (empty !== 1'b0 || newd !== 1'b0) $display("FAIL single_n1: got empty %b newd %b want 0 0", empty, newd);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (newd !== 1'b1 || dintx !== 8'hA5) $display("FAIL single_n2: got newd %b dintx %h want 1 a5", newd, dintx);
    else pass_cnt++;
    wait_obs(1, "single");
    wait_idle("single");
    total_cnt++;
    if (len_q.size() == 0 || len_q[0] != HOLD) $display("FAIL single_hold: got %0d want %0d", (len_q.size() > 0) ? len_q[0] : -1, HOLD);
    else pass_cnt++;
    total_cnt++;
    if (lat_q.size() == 0 || lat_q[0] != 30) $display("FAIL single_busy_lat: got %0d ns want 30", (lat_q.size() > 0) ? lat_q[0] : -1);
    else pass_cnt++;
    check_stream("single");
  endtask

  task automatic test_burst();
    int exp_lvl[3] = '{1, 1, 2};
    logic [7:0] bytes[3] = '{8'h11, 8'h22, 8'h33};
    gap_q.delete(); obs_q.delete();
    // The sequencer drains the first byte as soon as it lands.
    for (int i = 0; i < 3; i++) begin
      write_byte(bytes[i], 1'b1);
      total_cnt++;
      if (level !== 5'(exp_lvl[i])) $display("FAIL burst_level%0d: got %0d want %0d", i, level, exp_lvl[i]);
      else pass_cnt++;
    end
    wait_obs(3, "burst");
    wait_idle("burst");
    for (int i = 1; i < 3; i++) begin
      total_cnt++;
      if (gap_q.size() <= i || gap_q[i] != 40) $display("FAIL burst_gap%0d: got %0d ns want 40", i, (gap_q.size() > i) ? gap_q[i] : -1);
      else pass_cnt++;
    end
    check_stream("burst");
  endtask

  task automatic test_overflow();
    int b = 0;
    obs_q.delete();
    tx_stall = 1'b1;
    write_byte(8'hEE, 1'b1);
    while (!(busy && !newd) && b < 500) begin @(negedge clk); b++; end
    for (int i = 0; i < 16; i++) begin
      write_byte(8'(i), 1'b1);
      if (i == 14) begin
        total_cnt++;
        if (full !== 1'b0 || level !== 5'd15) $display("FAIL ovf_15: got full %b level %0d want 0 15", full, level);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (full !== 1'b1 || level !== 5'd16) $display("FAIL ovf_full: got full %b level %0d want 1 16", full, level);
    else pass_cnt++;
    write_byte(8'h10, 1'b0);
    total_cnt++;
    if (overflow !== 1'b1 || level !== 5'd16) $display("FAIL ovf_pulse: got overflow %b level %0d want 1 16", overflow, level);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_single: got %b want 0", overflow);
    else pass_cnt++;
    tx_stall = 1'b0;
    kick_req++;
    wait_obs(17, "ovf");
    wait_idle("ovf");
    check_stream("ovf");
  endtask

  task automatic test_wrap();
    int i = 0, b = 0;
    obs_q.delete();
    while (i < 40 && b < 20000) begin
      if (!full) begin write_byte(8'(i), 1'b1); i++; end
      else @(negedge clk);
      b++;
    end
    wait_obs(40, "wrap");
    wait_idle("wrap");
    check_stream("wrap");
  endtask

  task automatic test_reset_mid();
    int b = 0;
    write_byte(8'h77, 1'b0);
    write_byte(8'h78, 1'b0);
    while (!newd && b < 100) begin @(negedge clk); b++; end
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({newd, busy, empty, full} !== 4'b0010 || dintx !== 8'h00 || level !== 5'd0)
      $display("FAIL rstmid_async: got newd %b busy %b empty %b full %b dintx %h level %0d want 0 0 1 0 00 0",
               newd, busy, empty, full, dintx, level);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (empty !== 1'b1 || level !== 5'd0 || newd !== 1'b0) $display("FAIL rstmid_after: got empty %b level %0d newd %b want 1 0 0", empty, level, newd);
    else pass_cnt++;
    obs_q.delete(); exp_q.delete();
  endtask

`ifdef UART_TXQ_TIMEOUT_EN
  task automatic test_timeout();
    int b = 0, k = 0, r = 0;
    obs_q.delete();
    tx_stall = 1'b1;
    write_byte(8'h5A, 1'b1);
    write_byte(8'hC3, 1'b1);
    while (!newd && b < 100) begin @(negedge clk); b++; end
    while (newd && b < 500) begin @(negedge clk); b++; end
    // Now in the first WAIT_DONE cycle.
    while (!tx_timeout && k < 3000) begin @(negedge clk); k++; end
    total_cnt++;
    if (k != TMO) $display("FAIL tmo_cycles: got %0d want %0d", k, TMO);
    else pass_cnt++;
    while (!newd && r < 100) begin @(negedge clk); r++; end
    total_cnt++;
    if (r != 2 || dintx !== 8'hC3) $display("FAIL tmo_reissue: got %0d clks dintx %h want 2 c3", r, dintx);
    else pass_cnt++;
    tx_stall = 1'b0;
    wait_obs(2, "tmo");
    wait_idle("tmo");
    check_stream("tmo");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_reset_mid();
`ifdef UART_TXQ_TIMEOUT_EN
    test_timeout();
`else
    total_cnt++;
    if (tmo_seen != 0) $display("FAIL tmo_tied: got %0d pulses want 0", tmo_seen);
    else pass_cnt++;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
